// File: rtl/ni_local_injector.sv
// ni_local_injector: serialises descriptor + payload into header/size/payload flits for the router LOCAL port
module ni_local_injector #(
    parameter int FLIT_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FLIT_W-1:0] req_target,
    input  logic [FLIT_W-1:0] req_size,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [FLIT_W-1:0] pl_data,
    output logic              tx,
    output logic [FLIT_W-1:0] data_out,
    input  logic              credit_i,
    output logic              clock_tx,
    output logic              busy,
    output logic              pkt_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;
    state_t state_q, state_d;
    logic [FLIT_W-1:0] target_q, target_d, size_q, size_d, rem_q, rem_d;
    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [FLIT_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic empty, full, push, pop, xfer;

    always_comb begin
        empty    = cnt_q == '0;
        full     = cnt_q == CW'(FIFO_DEPTH);
        push     = pl_valid && !full;
        tx       = state_q == HEADER || state_q == SIZE || (state_q == PAYLOAD && !empty);
        data_out = state_q == HEADER ? target_q :
                   state_q == SIZE   ? size_q   :
                   (state_q == PAYLOAD && !empty) ? mem_q[rp_q] : '0;
        xfer     = tx && credit_i;
        pop      = state_q == PAYLOAD && xfer;
        state_d  = state_q;
        target_d = target_q;
        size_d   = size_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d  = HEADER;
                target_d = req_target;
                size_d   = req_size;
            end
            HEADER: if (credit_i) state_d = SIZE;
            SIZE: if (credit_i) begin
                if (size_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    rem_d   = size_q;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: if (xfer) begin
                rem_d = rem_q - FLIT_W'(1);
                if (rem_q == FLIT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_d = mem_q;
        if (push) mem_d[wp_q] = pl_data;
        wp_d  = wp_q + AW'(push);
        rp_d  = rp_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            size_q   <= '0;
            rem_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            size_q   <= size_d;
            rem_q    <= rem_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign pl_ready  = !full;
    assign pkt_done  = done_q;
    assign clock_tx  = clock;
endmodule
